sal_rd_resp_buf: RTL and testbench

- Read-return path of the DDR2 controller, sitting between the DFI read datapath and the AXI R channel.
- Holds one tag per accepted read request (ID plus burst count) and buffers the 128-bit read beats that come back from the DFI side.
- Drives AXI R as the responder: rid, rdata, rresp and rlast, with full rready backpressure.
- Reports free beat space so the scheduler only issues a DRAM read when the return data is guaranteed to fit.

---
 rtl/sal_rd_resp_buf.sv | 207 ++++++++++++++++++++
 tb/tb_sal_rd_resp_buf.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sal_rd_resp_buf.sv
// Read-return buffer between the DFI read datapath and the AXI R channel.
// Optional SAL_RDBUF_BYPASS_EN routes rd_data straight to R when the buffer is idle.
`timescale 1ns/1ps

module sal_rd_resp_buf #(
  parameter int unsigned DATA_WIDTH      = 128,
  parameter int unsigned ID_WIDTH        = 4,
  parameter int unsigned TAG_DEPTH       = 8,
  parameter int unsigned DATA_DEPTH      = 16,
  parameter int unsigned BEATS_PER_BURST = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tag_valid,
  output logic                          tag_ready,
  input  logic [ID_WIDTH-1:0]           tag_id,
  input  logic [3:0]                    tag_len,
  input  logic                          rd_valid,
  input  logic [DATA_WIDTH-1:0]         rd_data,
  output logic [$clog2(DATA_DEPTH):0]   buf_space,
  input  logic                          rsv_valid,
  output logic                          rvalid,
  input  logic                          rready,
  output logic [ID_WIDTH-1:0]           rid,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic [1:0]                    rresp,
  output logic                          rlast,
  output logic                          err
);

  localparam int unsigned TAG_AW  = $clog2(TAG_DEPTH);
  localparam int unsigned DATA_AW = $clog2(DATA_DEPTH);
  localparam int unsigned SPACE_W = DATA_AW + 1;
  localparam int unsigned TAG_W   = ID_WIDTH + 4;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned RSV_W   = SPACE_W + 1;
  localparam int unsigned SUM_W   = RSV_W + 1;

  // Index of the final beat; 5-bit arithmetic makes len=0 wrap to 32 beats.
  function automatic logic [CNT_W-1:0] f_last_idx(input logic [3:0] len);
    return CNT_W'(CNT_W'(len) * CNT_W'(BEATS_PER_BURST)) - CNT_W'(1);
  endfunction

  // Storage and state
  logic [TAG_W-1:0]      r_tag_mem [TAG_DEPTH];
  logic [TAG_AW:0]       r_tag_wptr;
  logic [TAG_AW:0]       r_tag_rptr;
  logic [DATA_WIDTH-1:0] r_dat_mem [DATA_DEPTH];
  logic [DATA_AW:0]      r_dat_wptr;
  logic [DATA_AW:0]      r_dat_rptr;
  logic [CNT_W-1:0]      r_beat_cnt;
  logic [RSV_W-1:0]      r_rsv_cnt;
  logic [SPACE_W-1:0]    r_buf_space;
  logic                  r_err;
  logic                  r_rvalid;
  logic                  r_rlast;
  logic [ID_WIDTH-1:0]   r_rid;
  logic [DATA_WIDTH-1:0] r_rdata;

  // Combinational control
  logic                  w_rvalid;
  logic                  w_rlast;
  logic                  w_byp;
  logic                  w_hs;
  logic [TAG_AW:0]       w_tag_cnt;
  logic [TAG_AW:0]       w_tag_left;
  logic [TAG_AW:0]       w_tag_wptr_nxt;
  logic [TAG_AW:0]       w_tag_rptr_nxt;
  logic                  w_tag_empty;
  logic                  w_tag_full;
  logic                  w_tag_push;
  logic                  w_tag_pop;
  logic                  w_tag_ne_nxt;
  logic [TAG_W-1:0]      w_tag_head_nxt;
  logic [DATA_AW:0]      w_dat_cnt;
  logic [DATA_AW:0]      w_dat_left;
  logic [DATA_AW:0]      w_dat_wptr_nxt;
  logic [DATA_AW:0]      w_dat_rptr_nxt;
  logic [DATA_AW:0]      w_dat_cnt_nxt;
  logic                  w_dat_empty;
  logic                  w_dat_full;
  logic                  w_dat_push;
  logic                  w_dat_pop;
  logic                  w_dat_ne_nxt;
  logic [DATA_WIDTH-1:0] w_dat_head_nxt;
  logic                  w_drop;
  logic                  w_orphan;
  logic                  w_rsv_over;
  logic [CNT_W-1:0]      w_beat_nxt;
  logic                  w_last_nxt;
  logic                  w_valid_nxt;
  logic                  w_rsv_dec;
  logic [SUM_W-1:0]      w_rsv_sum;
  logic [RSV_W-1:0]      w_rsv_nxt;
  logic [SUM_W-1:0]      w_used;
  logic [SPACE_W-1:0]    w_space_nxt;

  // FIFO status from the extra-wrap-bit pointers
  assign w_tag_cnt   = r_tag_wptr - r_tag_rptr;
  assign w_tag_empty = (r_tag_wptr == r_tag_rptr);
  assign w_tag_full  = (r_tag_wptr[TAG_AW] != r_tag_rptr[TAG_AW]) &&
                       (r_tag_wptr[TAG_AW-1:0] == r_tag_rptr[TAG_AW-1:0]);
  assign w_dat_cnt   = r_dat_wptr - r_dat_rptr;
  assign w_dat_empty = (r_dat_wptr == r_dat_rptr);
  assign w_dat_full  = (r_dat_wptr[DATA_AW] != r_dat_rptr[DATA_AW]) &&
                       (r_dat_wptr[DATA_AW-1:0] == r_dat_rptr[DATA_AW-1:0]);

  assign w_hs       = w_rvalid && rready;
  assign w_tag_push = tag_valid && !w_tag_full;
  assign w_tag_pop  = w_hs && w_rlast;
  assign w_dat_pop  = w_hs && !w_byp;
  assign w_dat_push = rd_valid && !(w_byp && rready) && (!w_dat_full || w_dat_pop);
  assign w_drop     = rd_valid && w_dat_full && !w_dat_pop;
  assign w_orphan   = rd_valid && w_tag_empty;
  assign w_rsv_over = rsv_valid && (r_buf_space < SPACE_W'(BEATS_PER_BURST));

  assign w_tag_wptr_nxt = r_tag_wptr + (TAG_AW+1)'(w_tag_push);
  assign w_tag_rptr_nxt = r_tag_rptr + (TAG_AW+1)'(w_tag_pop);
  assign w_dat_wptr_nxt = r_dat_wptr + (DATA_AW+1)'(w_dat_push);
  assign w_dat_rptr_nxt = r_dat_rptr + (DATA_AW+1)'(w_dat_pop);
  assign w_dat_cnt_nxt  = w_dat_wptr_nxt - w_dat_rptr_nxt;

  // Post-update heads: an incoming entry becomes head when the FIFO drains to empty this cycle
  assign w_tag_left     = w_tag_cnt - (TAG_AW+1)'(w_tag_pop);
  assign w_tag_ne_nxt   = (w_tag_left != '0) || w_tag_push;
  assign w_tag_head_nxt = (w_tag_left == '0) ? {tag_id, tag_len}
                                             : r_tag_mem[w_tag_rptr_nxt[TAG_AW-1:0]];
  assign w_dat_left     = w_dat_cnt - (DATA_AW+1)'(w_dat_pop);
  assign w_dat_ne_nxt   = (w_dat_left != '0) || w_dat_push;
  assign w_dat_head_nxt = (w_dat_left == '0) ? rd_data
                                             : r_dat_mem[w_dat_rptr_nxt[DATA_AW-1:0]];

  assign w_beat_nxt  = w_tag_pop ? '0 : (w_hs ? r_beat_cnt + CNT_W'(1) : r_beat_cnt);
  assign w_last_nxt  = w_tag_ne_nxt && (w_beat_nxt == f_last_idx(w_tag_head_nxt[3:0]));
  assign w_valid_nxt = w_tag_ne_nxt && w_dat_ne_nxt;

  // Reservations saturate rather than wrap so an overbooked scheduler only reads zero space
  assign w_rsv_dec   = rd_valid && (r_rsv_cnt != '0);
  assign w_rsv_sum   = SUM_W'(r_rsv_cnt)
                     + (rsv_valid ? SUM_W'(BEATS_PER_BURST) : SUM_W'(0))
                     - SUM_W'(w_rsv_dec);
  assign w_rsv_nxt   = w_rsv_sum[RSV_W] ? '1 : w_rsv_sum[RSV_W-1:0];
  assign w_used      = SUM_W'(w_dat_cnt_nxt) + SUM_W'(w_rsv_nxt);
  assign w_space_nxt = (w_used >= SUM_W'(DATA_DEPTH)) ? '0
                                                      : SPACE_W'(SUM_W'(DATA_DEPTH) - w_used);

  always_ff @(posedge clk) begin
    if (w_tag_push) r_tag_mem[r_tag_wptr[TAG_AW-1:0]] <= {tag_id, tag_len};
    if (w_dat_push) r_dat_mem[r_dat_wptr[DATA_AW-1:0]] <= rd_data;
  end

  // Output stage mirrors the post-update FIFO heads, giving one beat per clock with no bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_wptr  <= '0;
      r_tag_rptr  <= '0;
      r_dat_wptr  <= '0;
      r_dat_rptr  <= '0;
      r_beat_cnt  <= '0;
      r_rsv_cnt   <= '0;
      r_buf_space <= SPACE_W'(DATA_DEPTH);
      r_err       <= 1'b0;
      r_rvalid    <= 1'b0;
      r_rlast     <= 1'b0;
      r_rid       <= '0;
      r_rdata     <= '0;
    end else begin
      r_tag_wptr  <= w_tag_wptr_nxt;
      r_tag_rptr  <= w_tag_rptr_nxt;
      r_dat_wptr  <= w_dat_wptr_nxt;
      r_dat_rptr  <= w_dat_rptr_nxt;
      r_beat_cnt  <= w_beat_nxt;
      r_rsv_cnt   <= w_rsv_nxt;
      r_buf_space <= w_space_nxt;
      r_err       <= r_err || w_drop || w_orphan || w_rsv_over;
      r_rvalid    <= w_valid_nxt;
      r_rlast     <= w_valid_nxt && w_last_nxt;
      r_rid       <= w_tag_ne_nxt ? w_tag_head_nxt[TAG_W-1:4] : '0;
      r_rdata     <= w_dat_ne_nxt ? w_dat_head_nxt : '0;
    end
  end

`ifdef SAL_RDBUF_BYPASS_EN
  logic w_byp_last;

  // Idle buffer with a waiting tag: present the DFI word on R in the same cycle
  assign w_byp      = rd_valid && w_dat_empty && !w_tag_empty && !r_rvalid;
  assign w_byp_last = (r_beat_cnt == f_last_idx(r_tag_mem[r_tag_rptr[TAG_AW-1:0]][3:0]));
  assign w_rvalid   = r_rvalid || w_byp;
  assign w_rlast    = w_byp ? w_byp_last : r_rlast;
  assign rdata      = w_byp ? rd_data : r_rdata;
`else
  assign w_byp      = 1'b0;
  assign w_rvalid   = r_rvalid;
  assign w_rlast    = r_rlast;
  assign rdata      = r_rdata;
`endif

  assign rvalid    = w_rvalid;
  assign rlast     = w_rlast;
  assign rid       = r_rid;
  assign rresp     = 2'b00;
  assign err       = r_err;
  assign tag_ready = !w_tag_full;
  assign buf_space = r_buf_space;

endmodule

// File: tb/tb_sal_rd_resp_buf.sv
// Scoreboard bench for sal_rd_resp_buf: expected R beats are queued as tags/data are driven.
`timescale 1ns/1ps

module tb_sal_rd_resp_buf;

  logic         clk;
  logic         rst_n;
  logic         tag_valid;
  logic         tag_ready;
  logic [3:0]   tag_id;
  logic [3:0]   tag_len;
  logic         rd_valid;
  logic [127:0] rd_data;
  logic [4:0]   buf_space;
  logic         rsv_valid;
  logic         rvalid;
  logic         rready;
  logic [3:0]   rid;
  logic [127:0] rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         err;

  typedef struct packed {
    logic [3:0]   id;
    logic [127:0] data;
    logic         last;
  } beat_t;

  beat_t sb[$];
  int    hs_cyc[$];
  int    n_chk      = 0;
  int    n_fail     = 0;
  int    beat_total = 0;
  int    cyc_n      = 0;
  int    b0;

  sal_rd_resp_buf dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tag_valid (tag_valid),
    .tag_ready (tag_ready),
    .tag_id    (tag_id),
    .tag_len   (tag_len),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .buf_space (buf_space),
    .rsv_valid (rsv_valid),
    .rvalid    (rvalid),
    .rready    (rready),
    .rid       (rid),
    .rdata     (rdata),
    .rresp     (rresp),
    .rlast     (rlast),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [127:0] mkword(input int n);
    logic [31:0] v;
    v = 32'(n);
    return {v, ~v, v ^ 32'h5A5A_5A5A, 32'hC0DE_0000 + v};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_tag(input logic [3:0] id, input logic [3:0] len);
    tag_valid = 1'b1;
    tag_id    = id;
    tag_len   = len;
    cyc();
    tag_valid = 1'b0;
  endtask

  // Expected beats for one request: len=0 means 16 bursts, 2 beats per burst
  task automatic exp_tag(input logic [3:0] id, input logic [3:0] len, input int base);
    beat_t e;
    int    n;
    n = ((len == 4'd0) ? 16 : int'(len)) * 2;
    for (int b = 0; b < n; b++) begin
      e.id   = id;
      e.data = mkword(base + b);
      e.last = (b == n - 1);
      sb.push_back(e);
    end
  endtask

  task automatic send_words(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      rd_valid = 1'b1;
      rd_data  = mkword(base + i);
      cyc();
    end
    rd_valid = 1'b0;
  endtask

  task automatic wait_beats(input int target, input int budget);
    int k;
    k = 0;
    while (beat_total < target && k < budget) begin
      cyc();
      k++;
    end
    chk_eq("beat_count", 128'(beat_total), 128'(target));
  endtask

  task automatic rst_pulse();
    tag_valid = 1'b0;
    rd_valid  = 1'b0;
    rsv_valid = 1'b0;
    rst_n     = 1'b0;
    sb.delete();
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  // R monitor: handshakes are judged mid-cycle where inputs and outputs are settled
  always @(negedge clk) begin
    beat_t e;
    if (rst_n && rvalid && rready) begin
      chk_eq("sb_nonempty", 128'(sb.size() != 0), 128'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk_eq("rid", 128'(rid), 128'(e.id));
        chk_eq("rdata", rdata, e.data);
        chk_eq("rlast", 128'(rlast), 128'(e.last));
        chk_eq("rresp", 128'(rresp), 128'(0));
      end
      beat_total++;
      hs_cyc.push_back(cyc_n);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b1;
    tag_valid = 1'b0;
    tag_id    = '0;
    tag_len   = '0;
    rd_valid  = 1'b0;
    rd_data   = '0;
    rsv_valid = 1'b0;
    rready    = 1'b0;
    #2 rst_n  = 1'b0;
    repeat (3) cyc();

    chk_eq("rst_rvalid", 128'(rvalid), 128'(0));
    chk_eq("rst_rlast", 128'(rlast), 128'(0));
    chk_eq("rst_rid", 128'(rid), 128'(0));
    chk_eq("rst_rdata", rdata, 128'(0));
    chk_eq("rst_err", 128'(err), 128'(0));
    chk_eq("rst_tag_ready", 128'(tag_ready), 128'(1));
    chk_eq("rst_buf_space", 128'(buf_space), 128'(16));
    rst_n = 1'b1;
    cyc();

    // Single read with reservation
    rready    = 1'b1;
    rsv_valid = 1'b1;
    sb.push_back(beat_t'{id: 4'd0, data: 128'h5555_5555_6666_6666_7777_7777_8888_8888, last: 1'b0});
    sb.push_back(beat_t'{id: 4'd0, data: 128'h1111_1111_2222_2222_3333_3333_4444_4444, last: 1'b1});
    push_tag(4'd0, 4'd1);
    rsv_valid = 1'b0;
    chk_eq("space_after_rsv", 128'(buf_space), 128'(14));
    rd_valid = 1'b1;
    rd_data  = 128'h5555_5555_6666_6666_7777_7777_8888_8888;
    cyc();
    rd_data  = 128'h1111_1111_2222_2222_3333_3333_4444_4444;
    cyc();
    rd_valid = 1'b0;
    wait_beats(2, 20);
    repeat (2) cyc();
    chk_eq("t1_buf_space", 128'(buf_space), 128'(16));
    chk_eq("t1_err", 128'(err), 128'(0));
    chk_eq("t1_rvalid_idle", 128'(rvalid), 128'(0));

    // Two reads back to back, no bubble across the tag boundary
    push_tag(4'd0, 4'd1);
    push_tag(4'd1, 4'd1);
    exp_tag(4'd0, 4'd1, 100);
    exp_tag(4'd1, 4'd1, 102);
    hs_cyc.delete();
    b0 = beat_total;
    send_words(100, 4);
    wait_beats(b0 + 4, 20);
    for (int k = 0; k < 3; k++) chk_eq("b2b_gap", 128'(hs_cyc[k+1] - hs_cyc[k]), 128'(1));

    // Backpressure: outputs must hold while rready is low
    rready = 1'b0;
    push_tag(4'd3, 4'd2);
    exp_tag(4'd3, 4'd2, 200);
    b0 = beat_total;
    send_words(200, 4);
    cyc();
    for (int k = 0; k < 5; k++) begin
      chk_eq("bp_rvalid", 128'(rvalid), 128'(1));
      chk_eq("bp_rid", 128'(rid), 128'(sb[0].id));
      chk_eq("bp_rdata", rdata, sb[0].data);
      chk_eq("bp_rlast", 128'(rlast), 128'(sb[0].last));
      cyc();
    end
    rready = 1'b1;
    cyc();
    rready = 1'b0;
    chk_eq("bp_one_beat", 128'(beat_total), 128'(b0 + 1));
    for (int k = 0; k < 5; k++) begin
      chk_eq("bp2_rdata", rdata, sb[0].data);
      chk_eq("bp2_rlast", 128'(rlast), 128'(sb[0].last));
      cyc();
    end
    rready = 1'b1;
    wait_beats(b0 + 4, 20);

    // Boundaries: tag FIFO full, reservations exhaust space, data FIFO overflow drops
    rst_pulse();
    rready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk_eq("tag_ready_free", 128'(tag_ready), 128'(1));
      push_tag(4'(i), 4'd1);
      exp_tag(4'(i), 4'd1, 300 + 2 * i);
    end
    chk_eq("tag_ready_full", 128'(tag_ready), 128'(0));
    tag_valid = 1'b1;
    tag_id    = 4'hF;
    tag_len   = 4'd1;
    cyc();
    tag_valid = 1'b0;
    rsv_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk_eq("space_rsv", 128'(buf_space), 128'(16 - 2 * (i + 1)));
    end
    rsv_valid = 1'b0;
    chk_eq("rsv_no_err", 128'(err), 128'(0));
    b0 = beat_total;
    send_words(300, 16);
    chk_eq("full_no_err", 128'(err), 128'(0));
    chk_eq("full_space", 128'(buf_space), 128'(0));
    rd_valid = 1'b1;
    rd_data  = mkword(999);
    cyc();
    rd_valid = 1'b0;
    chk_eq("overflow_err", 128'(err), 128'(1));
    rready = 1'b1;
    wait_beats(b0 + 16, 40);
    repeat (2) cyc();
    chk_eq("drain_rvalid", 128'(rvalid), 128'(0));
    chk_eq("drain_space", 128'(buf_space), 128'(16));
    chk_eq("drain_sb", 128'(sb.size()), 128'(0));

    // Reservation with insufficient space flags an error
    rst_pulse();
    rsv_valid = 1'b1;
    repeat (8) cyc();
    chk_eq("ovb_space", 128'(buf_space), 128'(0));
    chk_eq("ovb_pre_err", 128'(err), 128'(0));
    cyc();
    rsv_valid = 1'b0;
    chk_eq("ovb_err", 128'(err), 128'(1));
    rst_pulse();

    // Length 0 wraps to 32 beats
    rready = 1'b1;
    push_tag(4'd5, 4'd0);
    exp_tag(4'd5, 4'd0, 400);
    b0 = beat_total;
    send_words(400, 32);
    wait_beats(b0 + 32, 60);
    cyc();
    chk_eq("wrap_rvalid", 128'(rvalid), 128'(0));
    chk_eq("wrap_err", 128'(err), 128'(0));

    // Orphan data is held until a tag arrives
    exp_tag(4'd2, 4'd1, 500);
    b0 = beat_total;
    send_words(500, 1);
    chk_eq("orphan_err", 128'(err), 128'(1));
    for (int k = 0; k < 3; k++) begin
      chk_eq("orphan_hold", 128'(rvalid), 128'(0));
      cyc();
    end
    send_words(501, 1);
    push_tag(4'd2, 4'd1);
    wait_beats(b0 + 2, 20);

    // Asynchronous reset in the middle of a burst
    rst_pulse();
    rready = 1'b0;
    push_tag(4'd1, 4'd1);
    exp_tag(4'd1, 4'd1, 600);
    b0 = beat_total;
    send_words(600, 2);
    cyc();
    rready = 1'b1;
    cyc();
    rready = 1'b0;
    chk_eq("mid_beat1", 128'(beat_total), 128'(b0 + 1));
    chk_eq("mid_rvalid", 128'(rvalid), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    chk_eq("async_rvalid", 128'(rvalid), 128'(0));
    sb.delete();
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    chk_eq("post_space", 128'(buf_space), 128'(16));
    chk_eq("post_err", 128'(err), 128'(0));
    chk_eq("post_tag_ready", 128'(tag_ready), 128'(1));
    chk_eq("post_rvalid", 128'(rvalid), 128'(0));
    chk_eq("final_sb", 128'(sb.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
